// File: rtl/mul_pkg.sv
// Shared types and constants for the arbitrated signed multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned D_WIDTH1_DEF = 9;
    localparam int unsigned D_WIDTH2_DEF = 8;
    localparam int unsigned OUT_W        = D_WIDTH1_DEF + D_WIDTH2_DEF - 1;

    // Most-negative operands and the value each one is clamped to before issue.
    localparam logic [D_WIDTH1_DEF-1:0] A_MOST_NEG = 9'h100;
    localparam logic [D_WIDTH1_DEF-1:0] A_CLAMP    = 9'h101;
    localparam logic [D_WIDTH2_DEF-1:0] B_MOST_NEG = 8'h80;
    localparam logic [D_WIDTH2_DEF-1:0] B_CLAMP    = 8'h81;

endpackage

// File: rtl/mul_arb_mul.sv
// One-cycle registered sign-magnitude signed multiplier.
// Operands are expected to be pre-clamped away from the most-negative value.
module mul_arb_mul #(
    parameter int unsigned AWidth = 9,
    parameter int unsigned BWidth = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AWidth-1:0]         a,
    input  logic [BWidth-1:0]         b,
    output logic [AWidth+BWidth-2:0]  p
);
    localparam int unsigned PWidth = AWidth + BWidth - 1;

    logic [AWidth-2:0] mag_a;
    logic [BWidth-2:0] mag_b;
    logic [PWidth-2:0] mag_p;
    logic              neg;
    logic [PWidth-1:0] p_d;
    logic [PWidth-1:0] p_q;

    // Multiply magnitudes, then reapply the sign; a zero magnitude stays positive.
    always_comb begin
        mag_a = a[AWidth-1] ? (AWidth-1)'(-a) : a[AWidth-2:0];
        mag_b = b[BWidth-1] ? (BWidth-1)'(-b) : b[BWidth-2:0];
        mag_p = (PWidth-1)'(mag_a) * (PWidth-1)'(mag_b);
        neg   = (a[AWidth-1] ^ b[BWidth-1]) && (mag_p != '0);
        p_d   = neg ? -{1'b0, mag_p} : {1'b0, mag_p};
    end

    // Product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among N_REQ requesters,
// with a one-entry result slot per requester.
module mul_arb
    import mul_pkg::*;
#(
    parameter int unsigned D_WIDTH1 = D_WIDTH1_DEF,
    parameter int unsigned D_WIDTH2 = D_WIDTH2_DEF,
    parameter int unsigned N_REQ    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic [N_REQ-1:0]                         req_valid,
    output logic [N_REQ-1:0]                         req_ready,
    input  logic [N_REQ*D_WIDTH1-1:0]                req_a,
    input  logic [N_REQ*D_WIDTH2-1:0]                req_b,
    output logic [N_REQ-1:0]                         rsp_valid,
    input  logic [N_REQ-1:0]                         rsp_ready,
    output logic [N_REQ*(D_WIDTH1+D_WIDTH2-1)-1:0]   rsp_data,
    output logic                                     busy,
    output logic [15:0]                              op_cnt
);
    localparam int unsigned OW   = D_WIDTH1 + D_WIDTH2 - 1;
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [D_WIDTH1-1:0] AMostNeg = {1'b1, {(D_WIDTH1-1){1'b0}}};
    localparam logic [D_WIDTH1-1:0] AClamp   = {1'b1, {(D_WIDTH1-2){1'b0}}, 1'b1};
    localparam logic [D_WIDTH2-1:0] BMostNeg = {1'b1, {(D_WIDTH2-1){1'b0}}};
    localparam logic [D_WIDTH2-1:0] BClamp   = {1'b1, {(D_WIDTH2-2){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic              tag_valid_q;
    logic [IdxW-1:0]   tag_idx_q;
    logic [N_REQ-1:0]  slot_q;
    logic [OW-1:0]     data_q [N_REQ];
    logic [15:0]       cnt_q;

    logic [N_REQ-1:0]  inflight, elig_emp, elig_full;
    logic [IdxW-1:0]   cand, idx_emp, idx_full, gnt_idx;
    logic              found_emp, found_full, gnt_valid;
    logic [D_WIDTH1-1:0] op_a;
    logic [D_WIDTH2-1:0] op_b;
    logic [OW-1:0]     mul_p;

    // Mode FSM: grants only in RUN; DRAIN waits for the multiplier pipe to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StDrain;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if (!tag_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Eligibility split: empty-slot requesters win first; a full-slot requester is
    // only granted when nobody has an empty slot, and then only on its own pop.
    // This keeps every req_ready bit free of other requesters' rsp_ready.
    always_comb begin
        inflight = '0;
        if (tag_valid_q) inflight[tag_idx_q] = 1'b1;
        elig_emp  = req_valid & ~inflight & ~slot_q;
        elig_full = req_valid & ~inflight & slot_q;

        found_emp  = 1'b0;
        found_full = 1'b0;
        idx_emp    = '0;
        idx_full   = '0;
        cand       = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IdxW'((32'(ptr_q) + off) % N_REQ);
            if (!found_emp && elig_emp[cand]) begin
                found_emp = 1'b1;
                idx_emp   = cand;
            end
            if (!found_full && elig_full[cand]) begin
                found_full = 1'b1;
                idx_full   = cand;
            end
        end

        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (state_q == StRun && en) begin
            if (found_emp) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_emp;
            end else if (found_full && rsp_ready[idx_full]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_full;
            end
        end

        req_ready = '0;
        if (gnt_valid) req_ready[gnt_idx] = 1'b1;

        ptr_d = ptr_q;
        if (gnt_valid) ptr_d = IdxW'((32'(gnt_idx) + 32'd1) % N_REQ);
    end

    // Operand mux with most-negative clamping.
    always_comb begin
        op_a = req_a[32'(gnt_idx)*D_WIDTH1 +: D_WIDTH1];
        op_b = req_b[32'(gnt_idx)*D_WIDTH2 +: D_WIDTH2];
        if (op_a == AMostNeg) op_a = AClamp;
        if (op_b == BMostNeg) op_b = BClamp;
    end

    mul_arb_mul #(
        .AWidth (D_WIDTH1),
        .BWidth (D_WIDTH2)
    ) mul (
        .clk (clk),
        .rst (rst),
        .a   (op_a),
        .b   (op_b),
        .p   (mul_p)
    );

    // State, tag pipeline, result slots and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            tag_valid_q <= 1'b0;
            tag_idx_q   <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) data_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tag_valid_q <= gnt_valid;
            tag_idx_q   <= gnt_idx;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (tag_valid_q && 32'(tag_idx_q) == i) begin
                    slot_q[i] <= 1'b1;
                    data_q[i] <= mul_p;
                end else if (slot_q[i] && rsp_ready[i]) begin
                    slot_q[i] <= 1'b0;
                end
            end
            if (tag_valid_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    // Output packing.
    always_comb begin
        rsp_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) rsp_data[i*OW +: OW] = data_q[i];
    end

    assign rsp_valid = slot_q;
    assign op_cnt    = cnt_q;
    assign busy      = (state_q != StIdle) || tag_valid_q;

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter D_WIDTH1, default 9, signed operand A width (two's complement).
REQ-002 Parameter D_WIDTH2, default 8, signed operand B width (two's complement).
REQ-003 Parameter N_REQ, default 4, number of requesters; OUT_W = D_WIDTH1+D_WIDTH2-1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  enables new grants; deassert drains the block.
REQ-007 req_valid  in  N_REQ  per-requester operand valid.
REQ-008 req_ready  out  N_REQ  per-requester grant; at most one bit high per cycle.
REQ-009 req_a  in  N_REQ*D_WIDTH1  packed operand A; slice i belongs to requester i.
REQ-010 req_b  in  N_REQ*D_WIDTH2  packed operand B; slice i belongs to requester i.
REQ-011 rsp_valid  out  N_REQ  per-requester result valid.
REQ-012 rsp_ready  in  N_REQ  per-requester result accept.
REQ-013 rsp_data  out  N_REQ*OUT_W  packed signed products; slice i belongs to requester i.
REQ-014 busy  out  1  high when the state is not IDLE or any operation is in flight.
REQ-015 op_cnt  out  16  count of completed products, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL share one signed multiplier (1-cycle registered, sign-magnitude) among N_REQ requesters.
REQ-017 FSM states IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when nothing is in flight; DRAIN->RUN when en=1.
REQ-018 Grants SHALL occur only in RUN.
REQ-019 Requester i is eligible when all hold: req_valid[i]=1; its result slot is empty or being popped this cycle; it has no operation in flight.
REQ-020 Round-robin arbitration: search starts at pointer p and wraps modulo N_REQ; after a grant to i, p = (i+1) mod N_REQ.
REQ-021 Transfer occurs when req_valid[i]&req_ready[i]; req_ready SHALL NOT depend combinationally on rsp_ready of another requester.
REQ-022 An operand equal to the most negative value (A=-2^(D_WIDTH1-1), B=-2^(D_WIDTH2-1)) SHALL be clamped to most-negative+1 before issue.
REQ-023 Latency: a transfer in cycle t makes rsp_valid[i]=1 in cycle t+2 with rsp_data slice i = A*B, sign-extended to OUT_W bits.
REQ-024 A product of zero SHALL be all-zero (no negative zero).
REQ-025 Each requester has a one-entry result slot: it is set on write-back and cleared when rsp_valid[i]&rsp_ready[i]. rsp_data is held stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Throughput: one grant per cycle aggregate; back-to-back grants to different requesters are legal.
REQ-027 op_cnt SHALL increment on each write-back and saturate at 16'hFFFF.
REQ-028 A deassertion of en SHALL NOT cancel in-flight operations; they complete into their slots.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, p=0, in-flight tags invalid, slots empty, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, op_cnt=0.
REQ-030 An operation in flight when rst asserts SHALL be discarded and produce no response.
REQ-031 The multiplier's own reset SHALL be driven from rst so that it clears on the same edge.

Structure
REQ-032 The shared package mul_pkg SHALL hold the FSM state enum, OUT_W, and the operand saturation constants.
REQ-033 Exactly one multiplier sub-module instance, mul, SHALL be used; arbitration, tag pipeline, and slots live in mul_arb.

Verification
REQ-034 Single requester 0: a=9'h1FD (-3), b=8'h05 -> rsp_valid[0] at t+2, data 16'hFFF1 (-15).
REQ-035 Requester 2: a=9'h064 (100), b=8'hFE (-2) -> 16'hFF38; a=0, b=8'hF9 -> 16'h0000.
REQ-036 Clamp: a=9'h100, b=8'h01 -> 16'hFF01 (-255); a=9'h001, b=8'h80 -> 16'hFF81 (-127).
REQ-037 All 4 requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,...; op_cnt=8 after 8 write-backs.
REQ-038 Requester 1: rsp_ready=0 with slot full -> no further grant to 1 while others proceed; raising rsp_ready -> pop, then a re-grant is possible in the same cycle.
REQ-039 en drops one cycle after a grant -> state DRAIN, product delivered, state IDLE, busy=0; rst during in-flight -> no rsp_valid, all outputs 0.
